// File: rtl/adder_arbiter_32bit.sv
// Two-requester round-robin arbiter in front of a multi-cycle 32-bit ripple-carry adder.
// Optional feature macro: OVERFLOW_FLAG_EN adds a registered two's-complement overflow output (ovf).
module adder_arbiter_32bit #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    input  logic        cin0,
    input  logic        cin1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy,
    output logic        done,
    output logic        done_id,
    output logic [31:0] sum,
    output logic        c_out
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic        ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(LAT - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        last_id;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_cin;
    logic        op_id;
    logic [31:0] raw_sum;
    logic        raw_cout;
    logic        calc_last;
    logic        grant_any;

    // Tie goes to the requester that did not win last time (last_id).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && state == IDLE) begin
            gnt0 = req0 && (!req1 || last_id);
            gnt1 = req1 && (!req0 || !last_id);
        end
    end

    assign grant_any = gnt0 || gnt1;
    assign calc_last = (state == CALC) && (cnt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (calc_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (state == CALC && !calc_last) begin
            cnt <= cnt + 4'd1;
        end else begin
            cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_id <= 1'b1;
        end else if (grant_any) begin
            last_id <= gnt1;
        end
    end

    // Operand capture decouples the adder from the ports for the whole operation.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the capture registers are reset too, so the adder never settles on power-up garbage.
        if (rst) begin
            op_a   <= 32'd0;
            op_b   <= 32'd0;
            op_cin <= 1'b0;
            op_id  <= 1'b0;
        end else if (grant_any) begin
            op_a   <= gnt1 ? a1 : a0;
            op_b   <= gnt1 ? b1 : b0;
            op_cin <= gnt1 ? cin1 : cin0;
            op_id  <= gnt1;
        end
    end

    // Explicit ripple-carry chain; LAT cycles are budgeted for it to settle.
    always_comb begin
        logic c;
        // NOTE: blocking assignments here are intentional: the carry variable is rewritten each bit position.
        c       = op_cin;
        raw_sum = 32'd0;
        for (int i = 0; i < 32; i++) begin
            raw_sum[i] = op_a[i] ^ op_b[i] ^ c;
            c          = (op_a[i] & op_b[i]) | (c & (op_a[i] ^ op_b[i]));
        end
        raw_cout = c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum     <= 32'd0;
            c_out   <= 1'b0;
            done_id <= 1'b0;
        end else if (calc_last) begin
            sum     <= raw_sum;
            c_out   <= raw_cout;
            done_id <= op_id;
        end
    end

`ifdef OVERFLOW_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (calc_last) begin
            ovf <= (op_a[31] == op_b[31]) && (raw_sum[31] != op_a[31]);
        end
    end
`endif

endmodule

// File: tb/tb_adder_arbiter_32bit.sv
// Directed scoreboard bench for adder_arbiter_32bit; checks ovf only when OVERFLOW_FLAG_EN is defined.
module tb_adder_arbiter_32bit;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [31:0] a0, b0, a1, b1;
    logic        cin0, cin1;
    logic        gnt0, gnt1, busy, done, done_id, c_out;
    logic [31:0] sum;
`ifdef OVERFLOW_FLAG_EN
    logic        ovf;
`endif

    adder_arbiter_32bit #(.LAT(LAT)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .a0      (a0),
        .b0      (b0),
        .a1      (a1),
        .b1      (b1),
        .cin0    (cin0),
        .cin1    (cin1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .sum     (sum),
        .c_out   (c_out)
`ifdef OVERFLOW_FLAG_EN
        ,
        .ovf     (ovf)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic        id;
        logic [32:0] res;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic id);
        exp_t e;
        e.id  = id;
        e.res = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        e.ovf = (a[31] == b[31]) && (e.res[31] != a[31]);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output logic id, output int g);
        bit seen = 0;
        id = 1'b0;
        g  = cyc;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                seen = 1;
                chk("gnt_onehot", {63'd0, gnt0 & gnt1}, 64'd0);
                id = gnt1;
                g  = cyc;
                sb.push_back(gnt1 ? model(a1, b1, cin1, 1'b1) : model(a0, b0, cin0, 1'b0));
            end
        end
        if (!seen) chk("grant_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_done(input int g);
        bit   seen = 0;
        exp_t e;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                chk("done_latency", 64'(cyc - g), 64'(LAT + 1));
                if (sb.size() == 0) begin
                    chk("scoreboard_empty", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sum", {32'd0, sum}, {32'd0, e.res[31:0]});
                    chk("c_out", {63'd0, c_out}, {63'd0, e.res[32]});
                    chk("done_id", {63'd0, done_id}, {63'd0, e.id});
`ifdef OVERFLOW_FLAG_EN
                    chk("ovf", {63'd0, ovf}, {63'd0, e.ovf});
`endif
                end
            end else begin
                chk("no_gnt_while_busy", {62'd0, gnt0, gnt1}, 64'd0);
            end
        end
        if (!seen) chk("done_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        logic id;
        int   g, prev_g, rf;

        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; cin0 = 1'b0; cin1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt", {62'd0, gnt0, gnt1}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_sum", {32'd0, sum}, 64'd0);
        chk("rst_c_out", {63'd0, c_out}, 64'd0);
        chk("rst_done_id", {63'd0, done_id}, 64'd0);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        rst = 1'b0;

        // Case 1: simple add from requester 0
        tick();
        a0 = 32'h5; b0 = 32'h3; cin0 = 1'b0; req0 = 1'b1;
        wait_grant(id, g);
        chk("case1_id", {63'd0, id}, 64'd0);
        tick();
        req0 = 1'b0;
        @(negedge clk);
        chk("case1_busy_calc", {63'd0, busy}, 64'd1);
        wait_done(g);

        // Case 2: wrap-around from requester 1, then result hold
        tick();
        a1 = 32'hFFFF_FFFF; b1 = 32'h0; cin1 = 1'b1; req1 = 1'b1;
        wait_grant(id, g);
        chk("case2_id", {63'd0, id}, 64'd1);
        tick();
        req1 = 1'b0;
        wait_done(g);
        @(negedge clk);
        chk("hold_done_low", {63'd0, done}, 64'd0);
        chk("hold_sum", {32'd0, sum}, 64'd0);
        chk("hold_c_out", {63'd0, c_out}, 64'd1);
        chk("hold_done_id", {63'd0, done_id}, 64'd1);

        // Case 3: both held, round-robin 0,1,0,1 at LAT+2 spacing
        tick();
        a0 = 32'd100; b0 = 32'd200; cin0 = 1'b1;
        a1 = 32'h8000_0000; b1 = 32'h8000_0000; cin1 = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        prev_g = 0;
        for (int i = 0; i < 4; i++) begin
            wait_grant(id, g);
            chk("rr_order", {63'd0, id}, 64'(i % 2));
            if (i > 0) chk("rr_spacing", 64'(g - prev_g), 64'(LAT + 2));
            prev_g = g;
            wait_done(g);
        end
        tick();
        req0 = 1'b0; req1 = 1'b0;

        // Case 4: reset in the second CALC cycle aborts; held request re-granted
        tick();
        a0 = 32'h1234; b0 = 32'h1111; cin0 = 1'b0; req0 = 1'b1;
        wait_grant(id, g);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_sum", {32'd0, sum}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_gnt", {62'd0, gnt0, gnt1}, 64'd0);
        sb.delete();
        tick();
        rst = 1'b0;
        rf = cyc;
        wait_grant(id, g);
        chk("regrant_cycle", 64'(g - rf), 64'd0);
        chk("regrant_id", {63'd0, id}, 64'd0);
        tick();
        req0 = 1'b0;
        wait_done(g);

        // Case 5: signed overflow patterns
        tick();
        a0 = 32'h7FFF_FFFF; b0 = 32'h1; cin0 = 1'b0; req0 = 1'b1;
        wait_grant(id, g);
        tick();
        req0 = 1'b0;
        wait_done(g);
        tick();
        a1 = 32'h8000_0000; b1 = 32'hFFFF_FFFF; cin1 = 1'b0; req1 = 1'b1;
        wait_grant(id, g);
        tick();
        req1 = 1'b0;
        wait_done(g);

        // Case 6: operands change right after the grant
        tick();
        a1 = 32'd10; b1 = 32'd20; cin1 = 1'b1; req1 = 1'b1;
        wait_grant(id, g);
        tick();
        req1 = 1'b0; a1 = 32'd1000; b1 = 32'd2000; cin1 = 1'b0;
        wait_done(g);

        // A few random operands from requester 0
        for (int i = 0; i < 3; i++) begin
            tick();
            a0 = $urandom; b0 = $urandom; cin0 = 1'($urandom_range(0, 1)); req0 = 1'b1;
            wait_grant(id, g);
            tick();
            req0 = 1'b0;
            wait_done(g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_arbiter_32bit.md
ADDER_ARBITER_32BIT -- requirements
Module: adder_arbiter_32bit

Interface
REQ-001 The block SHALL have parameter LAT, default 2, giving the number of CALC cycles allowed for 32-bit ripple-carry settling (legal range 1..15).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have ports req0/req1  input  1  add request from requester 0/1; held high until the matching grant.
REQ-005 The block SHALL have ports a0/a1, b0/b1  input  32  operands of requester 0/1; stable while the matching req is high.
REQ-006 The block SHALL have ports cin0/cin1  input  1  carry-in of requester 0/1.
REQ-007 The block SHALL have ports gnt0/gnt1  output  1  one-cycle grant; operands are captured on the edge that ends this cycle.
REQ-008 The block SHALL have port busy  output  1  high in CALC and DONE states.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse; sum, c_out and done_id are valid.
REQ-010 The block SHALL have port done_id  output  1  index of the requester that owns the current result.
REQ-011 The block SHALL have port sum  output  32  registered a+b+cin of the granted operation.
REQ-012 The block SHALL have port c_out  output  1  registered carry-out of the 32-bit add.

Function
REQ-013 The FSM SHALL have states IDLE, CALC and DONE: IDLE->CALC on any grant; CALC->DONE after LAT cycles; DONE->IDLE unconditionally.
REQ-014 In IDLE, gnt0/gnt1 SHALL be combinational from req0/req1 and the priority pointer; at most one is high, and both are low outside IDLE.
REQ-015 On a grant, the block SHALL capture the winner's a, b, cin and index into internal registers, ignoring later changes on the input ports.
REQ-016 Arbitration SHALL be round-robin: a single request always wins; when both requests are high, the requester not granted most recently wins.
REQ-017 The priority pointer SHALL update only on a grant.
REQ-018 The 33-bit result {c_out,sum} SHALL equal a+b+cin modulo 2^33, computed from the captured operands.
REQ-019 The result SHALL be registered on the CALC->DONE edge.
REQ-020 For a grant in cycle T, CALC SHALL span cycles T+1..T+LAT and done SHALL be high in cycle T+LAT+1 only.
REQ-021 sum, c_out and done_id SHALL hold their values after done until the next result is registered.
REQ-022 A requester SHALL be granted no earlier than the IDLE cycle after DONE, giving a throughput of one add per LAT+2 cycles.
REQ-023 Requests arriving during CALC or DONE SHALL wait, with no grant issued and nothing lost while req is held.
REQ-024 Wrap-around SHALL be handled as plain overflow: 0xFFFFFFFF+0x00000000+1 SHALL give sum=0, c_out=1.

Reset
REQ-025 While rst is high, the block SHALL force: state IDLE, CALC counter 0, sum 0, c_out 0, done 0, done_id 0, busy 0, and pointer such that requester 0 wins the first tie.
REQ-026 Reset asserted mid-CALC or in DONE SHALL abort the operation: no done pulse, and the result registers are cleared.
REQ-027 Both grants SHALL be low while rst is high.

Configuration
REQ-028 With OVERFLOW_FLAG_EN defined, the block SHALL add port ovf  output  1, registered with sum and reset to 0.
REQ-029 ovf SHALL be high when the operands have equal sign bits and sum[31] differs from them (two's-complement overflow).
REQ-030 Without OVERFLOW_FLAG_EN, the ovf port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-031 Case 1: LAT=2; req0 with a0=0x00000005, b0=0x00000003, cin0=0 -> gnt0 in cycle T, done in T+3, sum=0x00000008, c_out=0, done_id=0.
REQ-032 Case 2: req1 with a1=0xFFFFFFFF, b1=0x00000000, cin1=1 -> sum=0x00000000, c_out=1, done_id=1.
REQ-033 Case 3: req0 and req1 both held high for 4 operations -> grant order 0,1,0,1; each done exactly LAT+2 cycles apart.
REQ-034 Case 4: rst pulsed during the second CALC cycle -> no done pulse, sum=0; the held request is re-granted in the first IDLE cycle after rst falls.
REQ-035 Case 5 (OVERFLOW_FLAG_EN): 0x7FFFFFFF+0x00000001 -> ovf=1, sum=0x80000000; 0x80000000+0xFFFFFFFF -> ovf=1, c_out=1.
REQ-036 Case 6: operands changed on the input ports one cycle after the grant -> result reflects the captured operands only.
